// File: rtl/mag_tmu.sv
// rtl/mag_tmu.sv - multi-channel round-robin CORDIC vector magnitude unit
module mag_tmu #(
  parameter int DW   = 12,
  parameter int NCH  = 4,
  parameter int ITER = 12,
  localparam int CHW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    wr_en,
  input  logic [NCH*DW-1:0] x_in,
  input  logic [NCH*DW-1:0] y_in,
  output logic [DW-1:0]     mag_out,
  output logic [CHW-1:0]    mag_ch,
  output logic              mag_valid,
  input  logic              mag_ready,
  output logic              busy,
  output logic [NCH-1:0]    overrun
);

  // Working width: two guard bits so -2^(DW-1) negates and the CORDIC gain (~1.65) fits.
  localparam int WW = DW + 2;
  localparam int IW = $clog2(ITER);
  localparam int PW = WW + 15;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROT   = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [DW-1:0]        r_x_hold [NCH];
  logic [DW-1:0]        r_y_hold [NCH];
  logic [NCH-1:0]       r_pending;
  logic [NCH-1:0]       r_overrun;
  logic [CHW-1:0]       r_last;
  logic [CHW-1:0]       r_ch;
  logic [2:0]           r_state;
  logic [IW-1:0]        r_iter;
  logic signed [WW-1:0] r_wx;
  logic signed [WW-1:0] r_wy;
  logic [DW-1:0]        r_mag_out;
  logic [CHW-1:0]       r_mag_ch;

  logic                 w_grant_found;
  logic [CHW-1:0]       w_grant_ch;
  logic [CHW-1:0]       w_cand;
  logic                 w_grant;
  logic [DW-1:0]        w_sel_x;
  logic [DW-1:0]        w_sel_y;
  logic signed [WW-1:0] w_xs;
  logic signed [WW-1:0] w_ys;
  logic signed [WW-1:0] w_nx;
  logic signed [WW-1:0] w_ny;
  logic [WW-2:0]        w_xpos;
  logic [DW:0]          w_scaled;
  logic [DW-1:0]        w_mag;

  // Round-robin search: first pending channel strictly after the last one served, with wrap.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_ch    = '0;
    w_cand        = r_last;
    for (int i = 0; i < NCH; i++) begin
      w_cand = (w_cand == CHW'(NCH - 1)) ? '0 : w_cand + CHW'(1);
      if (!w_grant_found && r_pending[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_ch    = w_cand;
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_grant_found;
  assign w_sel_x = r_x_hold[w_grant_ch];
  assign w_sel_y = r_y_hold[w_grant_ch];

  // One micro-rotation driving y toward zero; both updates use the pre-iteration values.
  always_comb begin
    w_xs = r_wx >>> r_iter;
    w_ys = r_wy >>> r_iter;
    if (!r_wy[WW-1]) begin
      w_nx = r_wx + w_ys;
      w_ny = r_wy - w_xs;
    end else begin
      w_nx = r_wx - w_ys;
      w_ny = r_wy + w_xs;
    end
  end

  // Gain compensation (x * 39797) >> 16, clamped at zero below and at 2^DW-1 above.
  always_comb begin
    w_xpos   = r_wx[WW-1] ? '0 : r_wx[WW-2:0];
    w_scaled = (DW + 1)'(({{16{1'b0}}, w_xpos} * PW'(39797)) >> 16);
    w_mag    = w_scaled[DW] ? '1 : w_scaled[DW-1:0];
  end

  // Channel holding registers, pending flags and overrun pulses; a write beats a grant clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_overrun <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_x_hold[k] <= '0;
        r_y_hold[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (wr_en[k]) begin
          r_x_hold[k]  <= x_in[k*DW +: DW];
          r_y_hold[k]  <= y_in[k*DW +: DW];
          r_pending[k] <= 1'b1;
        end else if (w_grant && (w_grant_ch == CHW'(k))) begin
          r_pending[k] <= 1'b0;
        end
        r_overrun[k] <= wr_en[k] && r_pending[k] && !(w_grant && (w_grant_ch == CHW'(k)));
      end
    end
  end

  // Engine sequence: grant+snapshot, pre-rotate, ITER rotations, scale, hold until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= CHW'(NCH - 1);
      r_ch      <= '0;
      r_iter    <= '0;
      r_wx      <= '0;
      r_wy      <= '0;
      r_mag_out <= '0;
      r_mag_ch  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_LOAD;
            r_ch    <= w_grant_ch;
            r_last  <= w_grant_ch;
            r_wx    <= {{2{w_sel_x[DW-1]}}, w_sel_x};
            r_wy    <= {{2{w_sel_y[DW-1]}}, w_sel_y};
          end
        end
        S_LOAD: begin
          if (r_wx[WW-1]) begin
            r_wx <= -r_wx;
            r_wy <= -r_wy;
          end
          r_iter  <= '0;
          r_state <= S_ROT;
        end
        S_ROT: begin
          r_wx <= w_nx;
          r_wy <= w_ny;
          if (r_iter == IW'(ITER - 1)) begin
            r_state <= S_SCALE;
          end else begin
            r_iter <= r_iter + IW'(1);
          end
        end
        S_SCALE: begin
          r_mag_out <= w_mag;
          r_mag_ch  <= r_ch;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (mag_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mag_out   = r_mag_out;
  assign mag_ch    = r_mag_ch;
  assign mag_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_mag_tmu.sv
// tb/tb_mag_tmu.sv - self-checking bench for mag_tmu
module tb_mag_tmu;
  localparam int DW   = 12;
  localparam int NCH  = 4;
  localparam int ITER = 12;
  localparam int CHW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    wr_en;
  logic [NCH*DW-1:0] x_in;
  logic [NCH*DW-1:0] y_in;
  logic [DW-1:0]     mag_out;
  logic [CHW-1:0]    mag_ch;
  logic              mag_valid;
  logic              mag_ready;
  logic              busy;
  logic [NCH-1:0]    overrun;

  mag_tmu #(.DW(DW), .NCH(NCH), .ITER(ITER)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .x_in(x_in), .y_in(y_in),
    .mag_out(mag_out), .mag_ch(mag_ch), .mag_valid(mag_valid),
    .mag_ready(mag_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int ch; int mag; } xfer_t;
  typedef struct { int ch; int x; int y; int exp; } vec_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  xfer_t xq[$];
  xfer_t rec;

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted results, captured mid-cycle ahead of the edge that completes the transfer.
  always @(negedge clk) begin
    if (!rst && mag_valid && mag_ready) begin
      rec.cyc = cyc;
      rec.ch  = int'(mag_ch);
      rec.mag = int'(mag_out);
      xq.push_back(rec);
    end
  end

  // Magnitude from the vectoring-CORDIC rules with unbounded integers.
  function automatic int ref_mag(int x, int y);
    longint wx = x;
    longint wy = y;
    longint nx;
    longint ny;
    longint m;
    if (wx < 0) begin
      wx = -wx;
      wy = -wy;
    end
    for (int i = 0; i < ITER; i++) begin
      if (wy >= 0) begin
        nx = wx + (wy >>> i);
        ny = wy - (wx >>> i);
      end else begin
        nx = wx - (wy >>> i);
        ny = wy + (wx >>> i);
      end
      wx = nx;
      wy = ny;
    end
    m = (wx * 39797) >>> 16;
    if (m < 0) m = 0;
    if (m > (2**DW - 1)) m = 2**DW - 1;
    return int'(m);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d+-%0d", name, act, exp, tol);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ch(input int ch, input int x, input int y);
    wr_en[ch] = 1'b1;
    x_in[ch*DW +: DW] = x[DW-1:0];
    y_in[ch*DW +: DW] = y[DW-1:0];
  endtask

  task automatic write_ch(input int ch, input int x, input int y);
    wr_en = '0;
    set_ch(ch, x, y);
    tick(1);
    wr_en = '0;
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int k = 0;
    while (xq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   g;
    int   v;
    int   n;
    int   bad;
    int   bad2;
    int   mo;
    int   mc;
    int   tb_last;
    int   rx[NCH];
    int   ry[NCH];
    int   exp_ch[$];
    logic [NCH-1:0] mask;

    vt[0] = '{0, 1000, 0, 1000};
    vt[1] = '{2, 300, -400, 500};
    vt[2] = '{1, -2048, -2048, 2896};
    vt[3] = '{3, 0, 0, 0};
    vt[4] = '{0, -2048, 0, 2048};
    vt[5] = '{2, 2047, -2047, 2895};

    rst = 1'b1;
    wr_en = '0;
    x_in = '0;
    y_in = '0;
    mag_ready = 1'b0;
    #12;
    check("rst_mag_out", int'(mag_out), 0);
    check("rst_mag_ch", int'(mag_ch), 0);
    check("rst_mag_valid", int'(mag_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed single-channel vectors: latency, value and handshake release.
    mag_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      xq.delete();
      write_ch(vt[i].ch, vt[i].x, vt[i].y);
      n = 0;
      while (!busy && n < 20) begin tick(1); n++; end
      g = cyc;
      n = 0;
      while (!mag_valid && n < 40) begin tick(1); n++; end
      v = cyc;
      check($sformatf("vec%0d_latency", i), v - g, ITER + 2);
      tick(1);
      check($sformatf("vec%0d_valid_drop", i), int'(mag_valid), 0);
      check($sformatf("vec%0d_count", i), xq.size(), 1);
      if (xq.size() > 0) begin
        check($sformatf("vec%0d_ch", i), xq[0].ch, vt[i].ch);
        check_near($sformatf("vec%0d_mag", i), xq[0].mag, vt[i].exp, 2);
        check($sformatf("vec%0d_model", i), xq[0].mag, ref_mag(vt[i].x, vt[i].y));
      end
      tick(2);
    end

    // All channels written together after reset: ch0..ch3, ITER+4 apart.
    do_reset();
    xq.delete();
    wr_en = '0;
    for (int k = 0; k < NCH; k++) set_ch(k, 100 * (k + 1), -50 * k);
    tick(1);
    wr_en = '0;
    wait_xfers(4, 200);
    check("burst_count", xq.size(), 4);
    for (int k = 0; k < NCH && k < xq.size(); k++) begin
      check($sformatf("burst%0d_ch", k), xq[k].ch, k);
      check($sformatf("burst%0d_mag", k), xq[k].mag, ref_mag(100 * (k + 1), -50 * k));
      if (k > 0) check($sformatf("burst%0d_gap", k), xq[k].cyc - xq[k-1].cyc, ITER + 4);
    end
    tick(2);

    // Backpressure: result must hold for 20 stalled cycles, then exactly one transfer.
    mag_ready = 1'b0;
    xq.delete();
    write_ch(2, -700, 240);
    n = 0;
    while (!mag_valid && n < 40) begin tick(1); n++; end
    mo = int'(mag_out);
    mc = int'(mag_ch);
    check("stall_mag", mo, ref_mag(-700, 240));
    check("stall_ch", mc, 2);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (!mag_valid || int'(mag_out) != mo || int'(mag_ch) != mc) bad++;
    end
    check("stall_stable", bad, 0);
    check("stall_no_xfer", xq.size(), 0);
    mag_ready = 1'b1;
    tick(5);
    check("stall_one_xfer", xq.size(), 1);
    check("stall_valid_drop", int'(mag_valid), 0);

    // Overrun on a double write; a write during that channel's own rotation yields a second result.
    xq.delete();
    write_ch(0, 500, 500);
    write_ch(1, 100, 0);
    write_ch(1, -600, 800);
    check("ovr_pulse", int'(overrun), 2);
    tick(1);
    check("ovr_pulse_end", int'(overrun), 0);
    wait_xfers(1, 60);
    tick(4);
    write_ch(1, -30, 40);
    check("ovr_none_in_rot", int'(overrun), 0);
    wait_xfers(3, 120);
    check("ovr_count", xq.size(), 3);
    if (xq.size() >= 3) begin
      check("ovr_first_ch", xq[0].ch, 0);
      check("ovr_second_ch", xq[1].ch, 1);
      check("ovr_second_mag", xq[1].mag, ref_mag(-600, 800));
      check("ovr_third_ch", xq[2].ch, 1);
      check("ovr_third_mag", xq[2].mag, ref_mag(-30, 40));
    end
    tick(2);

    // Write landing on the grant edge: set wins, no overrun, both data served in order.
    xq.delete();
    write_ch(3, 0, -900);
    write_ch(3, 700, 0);
    check("coinc_no_overrun", int'(overrun), 0);
    wait_xfers(2, 120);
    check("coinc_count", xq.size(), 2);
    if (xq.size() >= 2) begin
      check("coinc_first_mag", xq[0].mag, ref_mag(0, -900));
      check("coinc_second_ch", xq[1].ch, 3);
      check("coinc_second_mag", xq[1].mag, ref_mag(700, 0));
    end
    tick(2);

    // Asynchronous reset during rotation aborts the computation.
    write_ch(0, 1500, -200);
    tick(5);
    #3;
    rst = 1'b1;
    #1;
    check("abort_mag_out", int'(mag_out), 0);
    check("abort_mag_ch", int'(mag_ch), 0);
    check("abort_valid", int'(mag_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 0;
    bad2 = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (mag_valid) bad++;
      if (busy) bad2++;
    end
    check("abort_no_valid", bad, 0);
    check("abort_no_busy", bad2, 0);

    // Randomized rounds: random channel sets and data, random backpressure, round-robin order.
    do_reset();
    tb_last = NCH - 1;
    for (int r = 0; r < 20; r++) begin
      xq.delete();
      exp_ch.delete();
      mask = NCH'($urandom_range(1, 2**NCH - 1));
      wr_en = '0;
      for (int k = 0; k < NCH; k++) begin
        rx[k] = int'($urandom_range(0, 4095)) - 2048;
        ry[k] = int'($urandom_range(0, 4095)) - 2048;
        if (mask[k]) set_ch(k, rx[k], ry[k]);
      end
      for (int j = 1; j <= NCH; j++) begin
        if (mask[(tb_last + j) % NCH]) exp_ch.push_back((tb_last + j) % NCH);
      end
      tick(1);
      wr_en = '0;
      n = 0;
      while (xq.size() < exp_ch.size() && n < 600) begin
        mag_ready = 1'($urandom_range(0, 1));
        tick(1);
        n++;
      end
      mag_ready = 1'b0;
      check($sformatf("rnd%0d_count", r), xq.size(), exp_ch.size());
      for (int j = 0; j < exp_ch.size() && j < xq.size(); j++) begin
        check($sformatf("rnd%0d_%0d_ch", r, j), xq[j].ch, exp_ch[j]);
        check($sformatf("rnd%0d_%0d_mag", r, j), xq[j].mag, ref_mag(rx[exp_ch[j]], ry[exp_ch[j]]));
      end
      if (exp_ch.size() > 0) tb_last = exp_ch[exp_ch.size() - 1];
      tick(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mag_tmu.md
MAG_TMU -- requirements
Module: mag_tmu

Interface
REQ-001 Parameter DW, default 12: data width of each signed x/y channel operand and of the unsigned magnitude output.
REQ-002 Parameter NCH, default 4: number of input channels (legal range 2..16).
REQ-003 Parameter ITER, default 12: CORDIC micro-rotation count (legal range 4..DW+2).
REQ-004 Derived value CHW = clog2(NCH): channel-index width.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 wr_en  input  NCH  per-channel write strobe; bit k writes channel k.
REQ-008 x_in  input  NCH*DW  channel k x operand in slice [k*DW +: DW], two's complement.
REQ-009 y_in  input  NCH*DW  channel k y operand in slice [k*DW +: DW], two's complement.
REQ-010 mag_out  output  DW  unsigned magnitude sqrt(x^2+y^2) of the served channel.
REQ-011 mag_ch  output  CHW  index of the channel that mag_out belongs to.
REQ-012 mag_valid  output  1  result valid; held until accepted.
REQ-013 mag_ready  input  1  downstream accept; a transfer occurs when mag_valid and mag_ready are both 1 on a clock edge.
REQ-014 busy  output  1  engine not in IDLE.
REQ-015 overrun  output  NCH  one-cycle pulse on bit k when a write hits channel k while pending[k] is already 1.

Function
REQ-016 Each channel shall have x/y holding registers plus a pending bit; wr_en[k]=1 at an edge loads that channel's x/y slices and sets pending[k]=1.
REQ-017 Writes to different channels in the same cycle shall all be captured.
REQ-018 Engine FSM states shall be IDLE, LOAD, ROT, SCALE, OUT.
REQ-019 IDLE -> LOAD occurs when any pending bit is 1.
REQ-020 On the IDLE -> LOAD transition, a round-robin grant shall choose the first pending channel searching upward (with wrap) from last_served+1, and shall clear that channel's pending bit.
REQ-021 After reset, last_served = NCH-1, so channel 0 has first priority.
REQ-022 When a write to a channel coincides with its grant clear, the set shall win: pending stays 1, the new data is kept for a later service, and no overrun is flagged.
REQ-023 LOAD shall snapshot the granted channel's x/y; later writes to that channel shall not disturb the computation in flight.
REQ-024 LOAD shall apply pre-rotation into DW+2-bit signed working registers: if x<0 then x=-x and y=-y.
REQ-025 ROT shall last exactly ITER cycles; in iteration i (0..ITER-1): if y>=0 then x+=y>>>i, y-=x>>>i; otherwise x-=y>>>i, y+=x>>>i. Both updates use the pre-iteration values, with arithmetic shifts.
REQ-026 SCALE shall compute mag = (x_final * 39797) >> 16, where 39797 is the CORDIC gain compensation (1/K in Q0.16).
REQ-027 SCALE shall saturate mag to 2^DW-1 and register mag_out and mag_ch.
REQ-028 OUT shall assert mag_valid; mag_out and mag_ch stay stable until the handshake completes.
REQ-029 On handshake, mag_valid shall drop on the next edge and the FSM shall go to IDLE.
REQ-030 The latency from the grant edge to mag_valid=1 shall be ITER+2 cycles.
REQ-031 Back-to-back service: IDLE evaluates pending on the cycle after the handshake, giving a throughput of one result per ITER+4 cycles at most.
REQ-032 Inputs x=y=0 shall produce mag_out=0.
REQ-033 The most negative operand (-2^(DW-1)) shall negate without overflow because of the DW+2-bit working width.
REQ-034 busy shall be 1 in LOAD, ROT, SCALE and OUT.

Reset
REQ-035 While rst=1 (asynchronously), the FSM shall be in IDLE, all holding registers and pending bits shall be 0, and last_served = NCH-1.
REQ-036 While rst=1, the outputs shall be mag_out=0, mag_ch=0, mag_valid=0, busy=0, overrun=0.
REQ-037 Reset asserted mid-computation shall abort the computation; the result is discarded and no mag_valid is produced after release.
REQ-038 Operation shall resume on the first clock edge after rst deasserts.

Verification (defaults DW=12, NCH=4, ITER=12; tolerance +-2 LSB)
REQ-039 Channel 0 x=1000, y=0, mag_ready=1 -> mag_valid=1 exactly 14 cycles after the grant edge, mag_out=1000, mag_ch=0.
REQ-040 Channel 2 x=300, y=-400 -> mag_out=500, mag_ch=2; channel 1 x=-2048, y=-2048 -> mag_out=2896 (no wrap).
REQ-041 All four channels written in one cycle -> results emerge in order ch0, ch1, ch2, ch3, each one ITER+4 cycles apart.
REQ-042 mag_ready held 0 for 20 cycles during OUT -> mag_out and mag_ch stable and mag_valid=1 throughout; exactly one transfer occurs when mag_ready rises.
REQ-043 Channel 1 written twice while pending -> overrun[1] pulses for one cycle; the result uses the second data; a write during channel 1's own ROT yields a second result.
REQ-044 rst pulsed during ROT -> all outputs 0 immediately; after release, with no new writes, mag_valid stays 0 and busy stays 0.
